// File: rtl/md_alu.sv
// EX-stage arithmetic unit: combinational ALU plus a multi-cycle multiply/divide
// engine that owns HI/LO and flags busy while an operation is in flight.
module md_alu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic [2:0]       MDOp,
  input  logic             start,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy
);

  localparam int SW   = $clog2(WIDTH);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;

  // ---------------- combinational ALU ----------------
  logic [SW-1:0] shamt;
  assign shamt = A[SW-1:0];

  always_comb begin
    ALUOut = '0;
    case (ALUOp)
      4'd0:    ALUOut = A + B;
      4'd1:    ALUOut = A - B;
      4'd2:    ALUOut = A | B;
      4'd3:    ALUOut = B << shamt;
      4'd4:    ALUOut = A & B;
      4'd5:    ALUOut = A ^ B;
      4'd6:    ALUOut = ~(A | B);
      4'd7:    ALUOut = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd8:    ALUOut = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd9:    ALUOut = B >> shamt;
      4'd10:   ALUOut = $signed(B) >>> shamt;
      default: ALUOut = '0;
    endcase
  end

  // ---------------- multiply / divide datapath ----------------
  // One multiplier serves both signednesses: sign- or zero-extend to 2*WIDTH
  // and keep the low 2*WIDTH bits of the product.
  logic                 mul_signed;
  logic [2*WIDTH-1:0]   mul_a, mul_b, prod;
  assign mul_signed = (op_reg == MD_MULT);
  assign mul_a = {{WIDTH{mul_signed & a_reg[WIDTH-1]}}, a_reg};
  assign mul_b = {{WIDTH{mul_signed & b_reg[WIDTH-1]}}, b_reg};
  assign prod  = mul_a * mul_b;

  // Signed divide runs on magnitudes; MIN / -1 falls out naturally as MIN rem 0.
  logic             div_signed, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, div_q, div_r;
  assign div_signed = (op_reg == MD_DIV);
  assign a_neg  = div_signed & a_reg[WIDTH-1];
  assign b_neg  = div_signed & b_reg[WIDTH-1];
  assign a_mag  = a_neg ? (~a_reg + 1'b1) : a_reg;
  assign b_mag  = b_neg ? (~b_reg + 1'b1) : b_reg;
  assign b_zero = (b_reg == '0);
  assign b_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;

  always_comb begin
    div_q = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    div_r = a_neg ? (~r_mag + 1'b1) : r_mag;
    if (b_zero) begin
      div_q = '1;
      div_r = a_reg;
    end
  end

  logic             res_is_mul;
  logic [WIDTH-1:0] res_hi, res_lo;
  assign res_is_mul = (op_reg == MD_MULT) || (op_reg == MD_MULTU);
  assign res_hi = res_is_mul ? prod[2*WIDTH-1:WIDTH] : div_r;
  assign res_lo = res_is_mul ? prod[WIDTH-1:0]       : div_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (MDOp)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              a_next     = A;
              b_next     = B;
              op_next    = MDOp;
              cnt_next   = (MDOp == MD_MULT || MDOp == MD_MULTU) ? MUL_LOAD : DIV_LOAD;
              state_next = RUN;
            end
            MD_MTHI: hi_next = A;
            MD_MTLO: lo_next = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is deliberately not looked at here; the hazard unit stalls it.
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_LAST) begin
          hi_next    = res_hi;
          lo_next    = res_lo;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign HI   = hi_reg;
  assign LO   = lo_reg;
  assign busy = (state_reg == RUN);

endmodule

// File: tb/tb_md_alu.sv
// Directed self-checking bench for md_alu: a 32-bit default instance plus a
// 16-bit single-cycle-multiply instance.
module tb_md_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  ALUOp;
  logic [2:0]  MDOp;
  logic        start;
  logic [31:0] ALUOut, HI, LO;
  logic        busy;

  logic [15:0] A16, B16;
  logic [3:0]  ALUOp16;
  logic [2:0]  MDOp16;
  logic        start16;
  logic [15:0] ALUOut16, HI16, LO16;
  logic        busy16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  md_alu u_dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ALUOp(ALUOp), .MDOp(MDOp),
    .start(start), .ALUOut(ALUOut), .HI(HI), .LO(LO), .busy(busy)
  );

  md_alu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(10)) u_dut16 (
    .clk(clk), .reset(reset), .A(A16), .B(B16), .ALUOp(ALUOp16), .MDOp(MDOp16),
    .start(start16), .ALUOut(ALUOut16), .HI(HI16), .LO(LO16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    ALUOp = op; A = a; B = b;
    #1;
    check(tag, ALUOut, exp);
  endtask

  // Start an op, count busy cycles, optionally inject an mtlo mid-run, check result.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n, input bit inj,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    bit hold;
    logic [31:0] hi0, lo0;
    A = a; B = b; MDOp = op; start = 1'b1;
    tick();
    start = 1'b0; MDOp = 3'd0;
    hi0 = HI; lo0 = LO; hold = 1'b1; n = 0;
    while (busy && n < 100) begin
      n++;
      if (inj && n == 2) begin
        A = 32'h0000_1234; MDOp = 3'd6; start = 1'b1;
      end
      tick();
      start = 1'b0; MDOp = 3'd0;
      if (busy && (HI !== hi0 || LO !== lo0)) hold = 1'b0;
    end
    check({tag, "_busy_cycles"}, n, exp_n);
    check({tag, "_hold"}, {31'd0, hold}, 32'd1);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    int n;
    reset = 1'b1; A = '0; B = '0; ALUOp = '0; MDOp = '0; start = 1'b0;
    A16 = '0; B16 = '0; ALUOp16 = '0; MDOp16 = '0; start16 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);

    // ALU sweep
    alu("add",   4'd0,  32'hFFFF_FFFF, 32'h1, 32'h0000_0000);
    alu("sub",   4'd1,  32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE);
    alu("or",    4'd2,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    alu("and",   4'd4,  32'hFFFF_FFFF, 32'h1, 32'h0000_0001);
    alu("xor",   4'd5,  32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE);
    alu("nor",   4'd6,  32'h0000_FF00, 32'h0000_00FF, 32'hFFFF_0000);
    alu("slt",   4'd7,  32'hFFFF_FFFF, 32'h1, 32'h0000_0001);
    alu("slt_n", 4'd7,  32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000);
    alu("sltu",  4'd8,  32'hFFFF_FFFF, 32'h1, 32'h0000_0000);
    alu("sltu_t",4'd8,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
    alu("sll",   4'd3,  32'h0000_0024, 32'h1, 32'h0000_0010);
    alu("srl",   4'd9,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000);
    alu("sra",   4'd10, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000);
    alu("op15",  4'd15, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000);

    // multiply / divide, each started in the cycle right after the previous one ends
    run_md("mult",      3'd1, 32'hFFFF_FFFE, 32'h3,         5,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("mult_mtlo", 3'd1, 32'h0001_0000, 32'h0001_0000, 5,  1'b1, 32'h0000_0001, 32'h0000_0000);
    run_md("multu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("div",       3'd3, 32'hFFFF_FFF9, 32'h2,         10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu",      3'd4, 32'hFFFF_FFF9, 32'h2,         10, 1'b0, 32'h0000_0001, 32'h7FFF_FFFC);
    run_md("div_pn",    3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
    run_md("divu_z",    3'd4, 32'h0000_0005, 32'h0,         10, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF);
    run_md("div_z",     3'd3, 32'hFFFF_FFF9, 32'h0,         10, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_md("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'h0000_0000, 32'h8000_0000);

    // mthi / mtlo: one edge, no busy
    A = 32'h0000_CAFE; MDOp = 3'd5; start = 1'b1;
    tick();
    start = 1'b0; MDOp = 3'd0;
    check("mthi_hi", HI, 32'h0000_CAFE);
    check("mthi_busy", {31'd0, busy}, 32'h0);
    A = 32'h0000_BEEF; MDOp = 3'd6; start = 1'b1;
    tick();
    start = 1'b0; MDOp = 3'd0;
    check("mtlo_lo", LO, 32'h0000_BEEF);
    check("mtlo_hi_kept", HI, 32'h0000_CAFE);

    // reset in the 3rd busy cycle of a div
    A = 32'd100; B = 32'd7; MDOp = 3'd3; start = 1'b1;
    tick();
    start = 1'b0; MDOp = 3'd0;
    tick(); tick();
    check("rstmid_busy_before", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'h0);
    check("rstmid_hi", HI, 32'h0);
    check("rstmid_lo", LO, 32'h0);
    repeat (15) tick();
    check("rstmid_late_hi", HI, 32'h0);
    check("rstmid_late_lo", LO, 32'h0);
    check("rstmid_late_busy", {31'd0, busy}, 32'h0);

    // 16-bit instance, single-cycle multiply
    A16 = 16'hFFFF; B16 = 16'hFFFF; MDOp16 = 3'd2; start16 = 1'b1;
    tick();
    start16 = 1'b0; MDOp16 = 3'd0;
    n = 0;
    while (busy16 && n < 100) begin
      n++;
      tick();
    end
    check("w16_multu_cycles", n, 32'd1);
    check("w16_multu_hi", {16'd0, HI16}, 32'h0000_FFFE);
    check("w16_multu_lo", {16'd0, LO16}, 32'h0000_0001);
    ALUOp16 = 4'd3; A16 = 16'h0013; B16 = 16'h0001;
    #1;
    check("w16_sll", {16'd0, ALUOut16}, 32'h0000_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_alu.md
# md_alu

Parametrised-width execute-stage arithmetic unit for the pipelined MIPS core. It merges the combinational ALU with a multi-cycle multiply/divide engine that owns the HI/LO registers. The unit exposes a `busy` flag so the hazard unit can stall dependent `mfhi`/`mflo`/`mult`/`div` instructions. It sits in the EX stage, and its results are forwarded to EX/MEM.

## Interface
- `WIDTH`, default 32: datapath width; must be a power of two, at least 8.
- `MUL_CYCLES`, default 5: busy duration for mult/multu; at least 1.
- `DIV_CYCLES`, default 10: busy duration for div/divu; at least 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `A`  in  WIDTH  operand A (rs, or shamt zero-extended for shifts).
- `B`  in  WIDTH  operand B (rt or immediate).
- `ALUOp`  in  4  combinational operation select.
- `MDOp`  in  3  mult/div/move operation select.
- `start`  in  1  qualifies `MDOp` for one cycle.
- `ALUOut`  out  WIDTH  combinational result.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.
- `busy`  out  1  mult/div in progress.

## Operation
- `ALUOp` encodings and results (purely combinational, independent of `busy`; shift amount `S` = A[log2(WIDTH)-1:0]):
  - 0 add: A+B, wraps modulo 2^WIDTH, no overflow trap.
  - 1 sub: A−B.
  - 2 or: A|B.
  - 3 sll: B<<S.
  - 4 and: A&B.
  - 5 xor: A^B.
  - 6 nor: ~(A|B).
  - 7 slt: signed A<B, result zero-extended 0 or 1.
  - 8 sltu: unsigned A<B.
  - 9 srl: B>>S, logical.
  - 10 sra: B>>>S, arithmetic.
  - 11–15: 0.
- `MDOp` encodings:
  - 0 none.
  - 1 mult (signed).
  - 2 multu.
  - 3 div (signed).
  - 4 divu.
  - 5 mthi: HI←A.
  - 6 mtlo: LO←A.
  - 7 none.
- State machine IDLE / RUN, with a down-counter `cnt`.
  - IDLE, `start`=1, MDOp 1–4: capture A and B, load `cnt` with MUL_CYCLES or DIV_CYCLES, go to RUN.
  - IDLE, `start`=1, MDOp 5/6: write HI or LO at that edge; stay IDLE.
  - RUN: decrement `cnt`. On the edge where `cnt` reaches 0, write HI/LO from the captured operands and return to IDLE.
  - `start` while in RUN: ignored entirely, including mthi/mtlo. The hazard unit guarantees this never occurs in legal operation.
- Result rules (all computed from the operands captured at the start edge):
  - Multiply: full 2·WIDTH product. HI = upper half, LO = lower half.
  - Divide: LO = quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - Divide by zero, signed or unsigned: LO = all ones, HI = A.
  - Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0.
- `busy` = (state == RUN).

## Timing
- Reset values: `HI`=0, `LO`=0, `busy`=0, state IDLE, `cnt`=0. `ALUOut` follows its inputs combinationally.
- Reset mid-operation: the operation is discarded; HI/LO read 0 and `busy` reads 0 the cycle after the reset edge.
- Start sampled at edge E0:
  - `busy` is high from the cycle after E0 for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES).
  - HI/LO take their new values at edge E0+N, the same edge on which `busy` falls.
- Back-to-back: `start` may be asserted in the first cycle after `busy` falls. No dead cycle is required.
- mthi/mtlo: one-edge latency; no `busy` pulse.
- HI/LO never change while `busy`=1.
- The combinational path A/B/ALUOp → ALUOut has no register stage.

## Test plan
- **ALU sweep** (WIDTH=32): A=0xFFFFFFFF, B=1.
  - add → 0x00000000; sub → 0xFFFFFFFE; slt → 1; sltu → 0.
  - sra with A=4, B=0x80000000 → 0xF8000000.
  - ALUOp 15 → 0.
- **Signed multiply**: start mult, A=0xFFFFFFFE (−2), B=3.
  - `busy` high for exactly 5 cycles.
  - At the falling edge of `busy`: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **Signed divide**: start div, A=0xFFFFFFF9 (−7), B=2.
  - After 10 busy cycles: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Repeat with divu, same operands: LO=0x7FFFFFFC, HI=1.
- **Corner divides**:
  - divu 5/0 → LO=0xFFFFFFFF, HI=5.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Start-while-busy and reset**:
  - During a mult, assert mtlo with A=0x1234: LO is unaffected; the mult result lands on schedule.
  - Assert `reset` in the 3rd busy cycle of a div: the next cycle shows busy=0, HI=LO=0, and no later write occurs.
- **Parametrisation**: WIDTH=16, MUL_CYCLES=1.
  - multu 0xFFFF×0xFFFF → HI=0xFFFE, LO=0x0001 after one busy cycle.
  - sll with A=0x13 uses shift 3.
